reg_file_sb: RTL

- Parametrised successor to the ID-stage register file.
- Configurable data width, register count and read-port count; one write-back port.
- Integrated per-register pending-write scoreboard: a bit is set when an instruction that writes that register issues, and cleared when its write-back lands.
- Sits in the ID stage. Feeds operand data and busy flags to hazard/stall logic; write-back comes from the WB stage.

---
 rtl/reg_file_sb_pkg.sv | 22 ++
 rtl/reg_file_sb_sb_scoreboard.sv | 79 +++++++
 rtl/reg_file_sb.sv | 93 +++++++++
 3 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared constants, types and helpers for the register file with pending-write scoreboard.
package reg_file_sb_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int NRD_D   = 2;
    localparam int AW_D    = $clog2(NREGS_D);

    typedef logic [AW_D-1:0]   reg_addr_t;
    typedef logic [XLEN_D-1:0] xlen_t;

    // Number of set bits in a vector of up to 64 busy flags.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_file_sb_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, priority flush > issue > write-back,
// plus an incrementally maintained count of pending registers.
module sb_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREGS   = NREGS_D,
    parameter int AW      = $clog2(NREGS),
    parameter int R0_ZERO = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt,
    output logic             any_busy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [AW:0]      cnt_r;
    logic [AW:0]      cnt_nxt_s;
    logic             any_r;
    logic             iss_ok_s;
    logic             set_s;
    logic             clr_s;

    // Next busy vector and count; set/clr are exactly the 0->1 and 1->0 transitions.
    always_comb begin
        iss_ok_s = iss_valid && !flush
                   && !((R0_ZERO != 0) && (iss_rd == {AW{1'b0}}));
        set_s    = iss_ok_s && !busy_r[iss_rd];
        clr_s    = wb_valid && !flush && busy_r[wb_rd]
                   && !(iss_ok_s && (iss_rd == wb_rd));
        busy_nxt_s = busy_r;
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                busy_nxt_s[r] = 1'b0;
            end else if (iss_ok_s && (iss_rd == AW'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (wb_valid && (wb_rd == AW'(r))) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
        cnt_nxt_s = cnt_r;
        if (flush) begin
            cnt_nxt_s = {(AW+1){1'b0}};
        end else begin
            case ({set_s, clr_s})
                2'b10:   cnt_nxt_s = cnt_r + {{AW{1'b0}}, 1'b1};
                2'b01:   cnt_nxt_s = cnt_r - {{AW{1'b0}}, 1'b1};
                default: cnt_nxt_s = cnt_r;
            endcase
        end
    end

    // Busy state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_r <= {NREGS{1'b0}};
            cnt_r  <= {(AW+1){1'b0}};
            any_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
            any_r  <= (cnt_nxt_s != {(AW+1){1'b0}});
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = cnt_r;
    assign any_busy = any_r;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised ID-stage register file with integrated pending-write scoreboard.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN    = XLEN_D,
    parameter int NREGS   = NREGS_D,
    localparam int AW     = $clog2(NREGS),
    parameter int NRD     = NRD_D,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic [AW:0]       busy_cnt,
    output logic              any_busy
);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_s;
    logic             wr_en_s;

    assign wr_en_s = wb_valid && !((R0_ZERO != 0) && (wb_rd == {AW{1'b0}}));

    // Storage array: cleared on reset, written on write-back.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[wb_rd] <= wb_data;
        end else begin
            regs_r[wb_rd] <= regs_r[wb_rd];
        end
    end

    sb_scoreboard #(
        .NREGS   (NREGS),
        .AW      (AW),
        .R0_ZERO (R0_ZERO)
    ) u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .busy      (busy_s),
        .busy_cnt  (busy_cnt),
        .any_busy  (any_busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;
        logic            bsy_s;

        assign addr_s = rd_addr[k*AW +: AW];

        // Read mux; forwarding (when built in) sits before the hard-wired zero.
        always_comb begin
            data_s = regs_r[addr_s];
            bsy_s  = busy_s[addr_s];
`ifdef REG_FILE_SB_BYPASS_EN
            if (wb_valid && (wb_rd == addr_s)) begin
                data_s = wb_data;
                bsy_s  = (iss_valid && (iss_rd == addr_s)) ? busy_s[addr_s] : 1'b0;
            end else begin
                data_s = regs_r[addr_s];
            end
`endif
            if ((R0_ZERO != 0) && (addr_s == {AW{1'b0}})) begin
                data_s = {XLEN{1'b0}};
            end else begin
                bsy_s = bsy_s;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data_s;
        assign rd_busy[k]              = bsy_s;
    end

endmodule
